// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged UART reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_e;

    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_STAGES      = 3;
    localparam int DEF_STAGE_GAP   = 4;
    localparam int DEF_CNT_W       = 8;

    localparam int                RCNT_W   = 4;
    localparam logic [RCNT_W-1:0] RCNT_MAX = 4'd15;

    function automatic logic [RCNT_W-1:0] rcnt_sat_inc(input logic [RCNT_W-1:0] v);
        return (v == RCNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/reset_seq_timer.sv
// Saturating up-counter shared by the hold interval and the inter-stage gap.
module reset_seq_timer
    import reset_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             match_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags the edge on which the next increment lands on the terminal value.
    assign match_o = ((cnt_q + 1'b1) == term_i);

endmodule

// File: rtl/reset_sequencer.sv
// Holds all UART sub-domains in reset for a minimum time, then releases them
// one at a time in thermometer order; counts re-resets for debug readout.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGES      = DEF_STAGES,
    parameter int STAGE_GAP   = DEF_STAGE_GAP,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reset_req,
    output logic [STAGES-1:0] rst_stage_n,
    output logic              busy,
    output logic              ready,
    output logic [3:0]        reset_count
);

    seq_state_e        state_q;
    logic [STAGES-1:0] stage_q;
    logic              busy_q;
    logic              ready_q;
    logic [RCNT_W-1:0] rcnt_q;

    logic              tmr_clr;
    logic              tmr_load;
    logic              tmr_en;
    logic [CNT_W-1:0]  tmr_term;
    logic              tmr_match;
    logic [STAGES-1:0] stg_next;

    assign stg_next = (stage_q << 1) | STAGES'(1);

    always_comb begin
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_term = CNT_W'(HOLD_CYCLES);
        case (state_q)
            HOLD, RELEASE: begin
                if (state_q == RELEASE) begin
                    tmr_term = CNT_W'(STAGE_GAP);
                end
                if (reset_req) begin
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en   = 1'b1;
                    tmr_load = tmr_match;
                end
            end
            RUN:     tmr_clr = reset_req;
            default: tmr_clr = 1'b1;
        endcase
    end

    reset_seq_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (reset_n),
        .clr_i     (tmr_clr),
        .load_i    (tmr_load),
        .load_val_i('0),
        .en_i      (tmr_en),
        .term_i    (tmr_term),
        .match_o   (tmr_match)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HOLD;
            stage_q <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (!reset_req && tmr_match) begin
                        stage_q <= STAGES'(1);
                        if (STAGES == 1) begin
                            state_q <= RUN;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (reset_req) begin
                        state_q <= HOLD;
                        stage_q <= '0;
                        rcnt_q  <= rcnt_sat_inc(rcnt_q);
                    end else if (tmr_match) begin
                        stage_q <= stg_next;
                        if (stg_next == '1) begin
                            state_q <= RUN;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (reset_req) begin
                        state_q <= HOLD;
                        stage_q <= '0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        rcnt_q  <= rcnt_sat_inc(rcnt_q);
                    end
                end
                default: begin
                    // Corrupted state: fall back to a fully asserted HOLD.
                    state_q <= HOLD;
                    stage_q <= '0;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign rst_stage_n = stage_q;
    assign busy        = busy_q;
    assign ready       = ready_q;
    assign reset_count = rcnt_q;

    a_thermometer: assert property (@(posedge clk) disable iff (!reset_n)
        ((stage_q + STAGES'(1)) & stage_q) == '0);
    a_busy_ready: assert property (@(posedge clk) disable iff (!reset_n)
        busy_q != ready_q);

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the async reset controller; consumes its synchronous active-high reset pulse on `reset_req`.
- Holds all UART sub-domains in reset for a minimum hold time, then releases them one at a time in a fixed order.
- Reports sequencing status and keeps a saturating count of re-reset events for debug readout.

Parameters:
- HOLD_CYCLES, 16: consecutive clk edges with `reset_req`=0 required in HOLD before the first release; legal range ≥2.
- STAGES, 3: number of staged reset outputs; legal range 1..8.
- STAGE_GAP, 4: clk edges between successive stage releases; legal range ≥1.
- CNT_W, 8: width of the shared hold/gap counter; must satisfy 2^CNT_W > max(HOLD_CYCLES, STAGE_GAP).

Ports:
- clk  input  1  single clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- reset_req  input  1  synchronous active-high reset request from the async reset controller (guaranteed ≥2 cycles wide).
- rst_stage_n  output  STAGES  per-domain active-low resets; bit 0 is released first.
- busy  output  1  high while in HOLD or RELEASE.
- ready  output  1  high only in RUN (all stages released).
- reset_count  output  4  saturating count of re-resets accepted from RELEASE or RUN.

Behaviour:
- reset_n=0, asynchronous and immediate from any state:
  - state=HOLD, cnt=0, stage index=0.
  - rst_stage_n=all 0, busy=1, ready=0, reset_count=0.
- All outputs are registered; no combinational path from `reset_req` to any output.
- Edge numbering: edge 1 is the first posedge with reset_n=1.
- HOLD:
  - Edge with `reset_req`=1: cnt←0.
  - Edge with `reset_req`=0: cnt←cnt+1.
  - The edge on which cnt reaches HOLD_CYCLES moves to RELEASE and sets rst_stage_n[0]=1 on that same edge.
  - Defaults: stage 0 releases on edge 16.
- RELEASE:
  - Gap counter reloads on each release.
  - Stage k releases exactly STAGE_GAP edges after stage k-1.
  - Defaults: stage 1 on edge 20, stage 2 on edge 24.
  - On the edge that releases stage STAGES-1: state=RUN, busy=0, ready=1 (same edge).
  - STAGES=1: ready=1 on the edge stage 0 releases.
- RUN: holds until `reset_req`=1.
- reset_req=1 sampled in RELEASE or RUN. On that edge:
  - rst_stage_n=all 0, busy=1, ready=0.
  - state=HOLD, cnt=0.
  - reset_count increments, saturating at 15.
- reset_req=1 in HOLD: only restarts cnt; reset_count unchanged, so a multi-cycle request counts once.
- Released stage bits never toggle except all-together reassertion; a stage never re-releases before a fresh full HOLD.
- Invariants:
  - rst_stage_n is always thermometer-coded (bit k high implies bits <k high).
  - busy = !ready at all times after reset.
- Counter widths:
  - cnt saturates; it never wraps.
  - reset_count stays at 15 under further requests.

Decomposition:
- Package reset_seq_pkg:
  - state enum HOLD=2'd0, RELEASE=2'd1, RUN=2'd2 (2'd3 is illegal; it recovers to HOLD with all stages asserted).
  - Default parameter constants.
  - RCNT_W=4 and RCNT_MAX=15.
- One sub-module, reset_seq_timer:
  - Loadable CNT_W up-counter with clear, enable and a terminal-match flag.
  - Shared by HOLD timing and the inter-stage gap.
- FSM, thermometer shifter and reset_count stay in the top module.

Test Plan:
- Power-on (defaults): release reset_n, reset_req=0 → rst_stage_n=000 through edge 15; 001 @16; 011 @20; 111 @24; ready=1/busy=0 @24; reset_count=0.
- Request in RUN: pulse reset_req 2 cycles at edge 40 → rst_stage_n=000, ready=0 @40; HOLD restarts on the first req-low edge (42); stage 0 @57; reset_count=1.
- Request mid-RELEASE: reset_req=1 at edge 18 (stages=001) → 000 @18, busy stays 1, reset_count=1, full 16-edge hold before re-release.
- Request during HOLD: reset_req=1 on edges 10–11 → no release until 16 req-low edges later (stage 0 @27); reset_count=0.
- Saturation: 20 requests, each issued in RUN → reset_count reads 15 and stays 15.
- Async reset mid-RELEASE: reset_n=0 between edges 21 and 22 → rst_stage_n=000, ready=0, reset_count=0 immediately, before any further clk edge; sequence restarts from edge 1.
